// File: rtl/pc_controller_if.sv
// Control-flow bundle between the address builder / fetch side and pc_controller.
interface pc_controller_if;
    logic        stall;
    logic        instr_valid;
    logic [1:0]  flag_branch;
    logic [31:0] pc_target;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        redirect;
    logic        trap;

    modport master (
        output stall, instr_valid, flag_branch, pc_target, funct3, rs1_val, rs2_val,
        input  pc, pc_plus4, flush, redirect, trap
    );

    modport slave (
        input  stall, instr_valid, flag_branch, pc_target, funct3, rs1_val, rs2_val,
        output pc, pc_plus4, flush, redirect, trap
    );
endinterface

// File: rtl/pc_controller.sv
// PC register with branch resolution and a counted flush window after each taken redirect.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_controller #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC      = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    pc_controller_if.slave bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state;
    logic [2:0]  fcnt;
    logic [31:0] pc_q;
    logic        flush_q;
    logic        redirect_q;
    logic        trap_q;

    logic        cond;
    logic        taken;
    logic [31:0] tgt_raw;
    logic [31:0] tgt_eff;
    logic        misalign;
    logic [31:0] pc_next4;

    assign pc_next4 = pc_q + 32'd4;

    always_comb begin
        cond = 1'b0;
        case (bus.funct3)
            3'b000:  cond = (bus.rs1_val == bus.rs2_val);
            3'b001:  cond = (bus.rs1_val != bus.rs2_val);
            3'b100:  cond = ($signed(bus.rs1_val) <  $signed(bus.rs2_val));
            3'b101:  cond = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
            3'b110:  cond = (bus.rs1_val <  bus.rs2_val);
            3'b111:  cond = (bus.rs1_val >= bus.rs2_val);
            default: cond = 1'b0;
        endcase

        taken = 1'b0;
        case (bus.flag_branch)
            2'b01, 2'b10: taken = 1'b1;
            2'b11:        taken = cond;
            default:      taken = 1'b0;
        endcase

        tgt_raw = (bus.flag_branch == 2'b10) ? {bus.pc_target[31:1], 1'b0} : bus.pc_target;
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign = |tgt_raw[1:0];
    assign tgt_eff  = misalign ? TRAP_PC : tgt_raw;
`else
    // Without the trap the low bits are simply dropped; keep the otherwise-dead bits visible.
    logic unused_cfg;
    assign unused_cfg = ^{TRAP_PC, tgt_raw[1:0]};
    assign misalign   = 1'b0;
    assign tgt_eff    = {tgt_raw[31:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            fcnt       <= 3'd0;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            trap_q     <= 1'b0;
        end else if (!bus.stall) begin
            case (state)
                RUN: begin
                    if (bus.instr_valid && taken) begin
                        pc_q       <= tgt_eff;
                        redirect_q <= 1'b1;
                        flush_q    <= 1'b1;
                        trap_q     <= misalign;
                        fcnt       <= 3'(FLUSH_CYCLES);
                        state      <= FLUSH;
                    end else begin
                        pc_q       <= pc_next4;
                        redirect_q <= 1'b0;
                        flush_q    <= 1'b0;
                        trap_q     <= 1'b0;
                    end
                end
                FLUSH: begin
                    // Requests seen here belong to flushed instructions and are dropped.
                    pc_q       <= pc_next4;
                    redirect_q <= 1'b0;
                    trap_q     <= 1'b0;
                    fcnt       <= fcnt - 3'd1;
                    if (fcnt == 3'd1) begin
                        flush_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_next4;
    assign bus.flush    = flush_q;
    assign bus.redirect = redirect_q;
    assign bus.trap     = trap_q;
endmodule
